// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write path: scheduler states and
// default geometry of the 16x16 pixel buffer.
package fb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } fb_state_t;

   localparam int unsigned DEF_X_RESOL = 16;
   localparam int unsigned DEF_N_ROWS  = 16;
   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_ADDR_W  = 8;
   localparam int unsigned FB_DEPTH    = DEF_X_RESOL * DEF_N_ROWS;

endpackage

// File: rtl/fb_write_sched_if.sv
// Bundle of requester handshakes, clear control and frame-RAM write port
// seen by the write scheduler.
interface fb_write_sched_if #(
   parameter int unsigned ADDR_W = fb_pkg::DEF_ADDR_W,
   parameter int unsigned DATA_W = fb_pkg::DEF_DATA_W
);

   logic              clr_start;
   logic              clr_busy;

   logic              req0_valid;
   logic              req0_ready;
   logic [15:0]       req0_x;
   logic [15:0]       req0_y;
   logic [DATA_W-1:0] req0_data;

   logic              req1_valid;
   logic              req1_ready;
   logic [15:0]       req1_x;
   logic [15:0]       req1_y;
   logic [DATA_W-1:0] req1_data;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              oob_err;

   // Master: requesters plus the RAM-side observer; slave: the scheduler.
   modport master (
      output clr_start,
      output req0_valid, req0_x, req0_y, req0_data,
      output req1_valid, req1_x, req1_y, req1_data,
      input  clr_busy, req0_ready, req1_ready,
      input  mem_we, mem_addr, mem_data, oob_err
   );

   modport slave (
      input  clr_start,
      input  req0_valid, req0_x, req0_y, req0_data,
      input  req1_valid, req1_x, req1_y, req1_data,
      output clr_busy, req0_ready, req1_ready,
      output mem_we, mem_addr, mem_data, oob_err
   );

endinterface

// File: rtl/fb_coord_map.sv
// Pixel coordinate to frame-RAM address, X-major: addr = x*X_RESOL + y,
// with a full-width bounds check before truncation.
module fb_coord_map #(
   parameter int unsigned X_RESOL = fb_pkg::DEF_X_RESOL,
   parameter int unsigned N_ROWS  = fb_pkg::DEF_N_ROWS,
   parameter int unsigned ADDR_W  = fb_pkg::DEF_ADDR_W
) (
   input  logic [15:0]       x,
   input  logic [15:0]       y,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);

   logic [31:0] x_w;
   logic [31:0] y_w;

   assign x_w      = {16'h0000, x};
   assign y_w      = {16'h0000, y};
   assign in_range = (x_w < N_ROWS) && (y_w < X_RESOL);
   assign addr     = ADDR_W'(x_w * X_RESOL + y_w);

endmodule

// File: rtl/fb_write_sched.sv
// Frame-RAM write scheduler: round-robin between two pixel requesters with a
// full-buffer clear engine taking priority; one registered write per cycle.
module fb_write_sched
   import fb_pkg::*;
#(
   parameter int unsigned       X_RESOL   = DEF_X_RESOL,
   parameter int unsigned       N_ROWS    = DEF_N_ROWS,
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter int unsigned       DATA_W    = DEF_DATA_W,
   parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
   input logic              ACLK,
   input logic              ARESETn,
   fb_write_sched_if.slave  bus
);

   localparam int unsigned Depth = X_RESOL * N_ROWS;
   localparam int unsigned CntW  = $clog2(Depth + 1);

   fb_state_t         state_q, state_d;
   logic [CntW-1:0]   cnt_q;
   logic              last_grant_q;
   logic              grant;
   logic              grant_vld;
   logic              clr_done;

   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              oob_err_q;
   logic              clr_busy_q;

   logic [ADDR_W-1:0] addr0, addr1, addr_sel;
   logic              in_range0, in_range1, in_range_sel;
   logic [DATA_W-1:0] data_sel;

   fb_coord_map #(
      .X_RESOL (X_RESOL),
      .N_ROWS  (N_ROWS),
      .ADDR_W  (ADDR_W)
   ) u_map0 (
      .x        (bus.req0_x),
      .y        (bus.req0_y),
      .addr     (addr0),
      .in_range (in_range0)
   );

   fb_coord_map #(
      .X_RESOL (X_RESOL),
      .N_ROWS  (N_ROWS),
      .ADDR_W  (ADDR_W)
   ) u_map1 (
      .x        (bus.req1_x),
      .y        (bus.req1_y),
      .addr     (addr1),
      .in_range (in_range1)
   );

   // cnt_q is the next clear address; reaching Depth marks the sweep complete.
   assign clr_done = (cnt_q == CntW'(Depth));

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB:     if (bus.clr_start) state_d = CLEAR;
         CLEAR:   if (clr_done)      state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // Readies are held low under reset so requesters never see a grant then.
   always_comb begin
      grant     = 1'b0;
      grant_vld = 1'b0;
      if (ARESETn && (state_q == ARB) && !bus.clr_start) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_vld = 1'b1;
            grant     = ~last_grant_q;
         end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant     = 1'b0;
         end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
         end
      end
      bus.req0_ready = grant_vld && !grant;
      bus.req1_ready = grant_vld && grant;
   end

   assign addr_sel     = grant ? addr1 : addr0;
   assign in_range_sel = grant ? in_range1 : in_range0;
   assign data_sel     = grant ? bus.req1_data : bus.req0_data;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         oob_err_q    <= 1'b0;
         clr_busy_q   <= 1'b0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
      end else begin
         oob_err_q <= 1'b0;
         mem_we_q  <= 1'b0;
         unique case (state_q)
            ARB: begin
               if (bus.clr_start) begin
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= '0;
                  mem_data_q <= CLR_VALUE;
                  clr_busy_q <= 1'b1;
                  cnt_q      <= CntW'(1);
               end else if (grant_vld) begin
                  last_grant_q <= grant;
                  if (in_range_sel) begin
                     mem_we_q   <= 1'b1;
                     mem_addr_q <= addr_sel;
                     mem_data_q <= data_sel;
                  end else begin
                     oob_err_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               if (clr_done) begin
                  clr_busy_q <= 1'b0;
                  cnt_q      <= '0;
               end else begin
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= ADDR_W'(cnt_q);
                  mem_data_q <= CLR_VALUE;
                  cnt_q      <= cnt_q + CntW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign bus.oob_err  = oob_err_q;
   assign bus.clr_busy = clr_busy_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: vector table for arbitration and
// mapping, plus hand sequences for clear sweep and reset mid-clear.
module tb_fb_write_sched;
   import fb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fb_write_sched_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   fb_write_sched #(
      .X_RESOL   (16),
      .N_ROWS    (16),
      .ADDR_W    (8),
      .DATA_W    (8),
      .CLR_VALUE (8'h00)
   ) dut (
      .ACLK    (clk),
      .ARESETn (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic        v0;
      logic [15:0] x0;
      logic [15:0] y0;
      logic [7:0]  d0;
      logic        v1;
      logic [15:0] x1;
      logic [15:0] y1;
      logic [7:0]  d1;
      logic        r0;
      logic        r1;
      logic        we;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic        oob;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[16];

   function automatic vec_t mk(input logic v0, input logic [15:0] x0, input logic [15:0] y0,
                               input logic [7:0] d0, input logic v1, input logic [15:0] x1,
                               input logic [15:0] y1, input logic [7:0] d1, input logic r0,
                               input logic r1, input logic we, input logic [7:0] addr,
                               input logic [7:0] data, input logic oob);
      vec_t v;
      v.v0 = v0; v.x0 = x0; v.y0 = y0; v.d0 = d0;
      v.v1 = v1; v.x1 = x1; v.y1 = y1; v.d1 = d1;
      v.r0 = r0; v.r1 = r1; v.we = we; v.addr = addr; v.data = data; v.oob = oob;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [15:0] x0, input logic [15:0] y0,
                        input logic [7:0] d0, input logic v1, input logic [15:0] x1,
                        input logic [15:0] y1, input logic [7:0] d1);
      bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_data = d1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic found;

      // Arbitration history carries across rows; expectations follow it.
      vecs[0]  = mk(1, 2, 3, 8'h5A, 0, 0, 0, 0,     1, 0, 1, 8'd35,  8'h5A, 0);
      vecs[1]  = mk(1, 1, 0, 8'h11, 1, 0, 1, 8'h22, 0, 1, 1, 8'd1,   8'h22, 0);
      vecs[2]  = mk(1, 1, 0, 8'h11, 1, 0, 1, 8'h22, 1, 0, 1, 8'd16,  8'h11, 0);
      vecs[3]  = mk(1, 1, 0, 8'h11, 1, 0, 1, 8'h22, 0, 1, 1, 8'd1,   8'h22, 0);
      vecs[4]  = mk(1, 1, 0, 8'h11, 1, 0, 1, 8'h22, 1, 0, 1, 8'd16,  8'h11, 0);
      vecs[5]  = mk(1, 1, 0, 8'h11, 1, 0, 1, 8'h22, 0, 1, 1, 8'd1,   8'h22, 0);
      vecs[6]  = mk(1, 1, 0, 8'h11, 1, 0, 1, 8'h22, 1, 0, 1, 8'd16,  8'h11, 0);
      vecs[7]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 8'd16,  8'h11, 0);
      vecs[8]  = mk(0, 0, 0, 0,     1, 16, 0, 8'h33, 0, 1, 0, 8'd16, 8'h11, 1);
      vecs[9]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 8'd16,  8'h11, 0);
      vecs[10] = mk(0, 0, 0, 0,     1, 0, 16, 8'h44, 0, 1, 0, 8'd16, 8'h11, 1);
      vecs[11] = mk(1, 15, 15, 8'hFF, 0, 0, 0, 0,   1, 0, 1, 8'd255, 8'hFF, 0);
      vecs[12] = mk(0, 0, 0, 0,     1, 0, 0, 8'h01, 0, 1, 1, 8'd0,   8'h01, 0);
      vecs[13] = mk(1, 16'hFFFF, 0, 8'h99, 0, 0, 0, 0, 1, 0, 0, 8'd0, 8'h01, 1);
      vecs[14] = mk(1, 1, 1, 8'h66, 1, 3, 4, 8'h77, 0, 1, 1, 8'd52,  8'h77, 0);
      vecs[15] = mk(1, 1, 1, 8'h66, 1, 3, 4, 8'h77, 1, 0, 1, 8'd17,  8'h66, 0);

      bus.clr_start = 1'b0;
      drive(1, 2, 3, 8'h5A, 1, 0, 1, 8'h22);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset mem", {31'd0, bus.mem_we}, 32'd0);
      chk("reset addr/data", {16'd0, bus.mem_addr, bus.mem_data}, 32'd0);
      chk("reset busy/oob", {30'd0, bus.clr_busy, bus.oob_err}, 32'd0);
      chk("reset readies", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].v0, vecs[i].x0, vecs[i].y0, vecs[i].d0,
               vecs[i].v1, vecs[i].x1, vecs[i].y1, vecs[i].d1);
         #1;
         chk($sformatf("vec%0d ready", i), {30'd0, bus.req0_ready, bus.req1_ready},
             {30'd0, vecs[i].r0, vecs[i].r1});
         step();
         chk($sformatf("vec%0d mem", i),
             {14'd0, bus.mem_we, bus.mem_addr, bus.mem_data, bus.oob_err},
             {14'd0, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].oob});
      end

      // Clear request collides with a pending req0 pixel.
      drive(1, 0, 7, 8'hAB, 0, 0, 0, 0);
      bus.clr_start = 1'b1;
      #1;
      chk("clr start ready0", {31'd0, bus.req0_ready}, 32'd0);
      step();
      bus.clr_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("clr%0d", i), {14'd0, bus.mem_we, bus.clr_busy, bus.mem_addr, bus.mem_data},
             {14'd0, 1'b1, 1'b1, 8'(i), 8'h00});
         bus.clr_start = (i == 50);
         #1;
         chk($sformatf("clr%0d ready0", i), {31'd0, bus.req0_ready}, 32'd0);
         step();
      end
      bus.clr_start = 1'b0;
      chk("clr end state", {14'd0, bus.mem_we, bus.clr_busy, bus.mem_addr, bus.mem_data},
          {14'd0, 1'b0, 1'b0, 8'd255, 8'h00});
      chk("clr end ready0", {31'd0, bus.req0_ready}, 32'd1);
      step();
      chk("post clr write", {15'd0, bus.mem_we, bus.mem_addr, bus.mem_data},
          {15'd0, 1'b1, 8'd7, 8'hAB});
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("post clr idle", {30'd0, bus.mem_we, bus.clr_busy}, 32'd0);

      // Second sweep, aborted by reset once address 100 is on the bus.
      bus.clr_start = 1'b1;
      step();
      bus.clr_start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         if (bus.mem_we === 1'b1 && bus.mem_addr === 8'd100) found = 1'b1;
         else step();
      end
      chk("reach addr 100", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      step();
      chk("mid-clr reset", {13'd0, bus.mem_we, bus.clr_busy, bus.oob_err, bus.mem_addr,
          bus.mem_data}, 32'd0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 1, 0, 5, 8'h5C);
      #1;
      chk("post reset ready1", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd1);
      step();
      chk("post reset write", {15'd0, bus.mem_we, bus.mem_addr, bus.mem_data},
          {15'd0, 1'b1, 8'd5, 8'h5C});
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("final idle", {30'd0, bus.mem_we, bus.oob_err}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
